// File: rtl/wbf_pkg.sv
// Shared types and sizing for the weight buffer: FSM states, address/count widths, skid depth.
package wbf_pkg;

   localparam int WBF_DATA_WIDTH = 8;
   localparam int WBF_ADDR_WIDTH = 8;
   localparam int WBF_DEPTH      = 2 ** WBF_ADDR_WIDTH;
   localparam int WBF_NUM_WIDTH  = WBF_ADDR_WIDTH + 1;

   localparam int SKID_DEPTH     = 2;
   localparam int SKID_CNT_WIDTH = $clog2(SKID_DEPTH + 1);
   localparam int SKID_PTR_WIDTH = $clog2(SKID_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_SERVE,
      ST_DRAIN
   } wbf_state_e;

endpackage

// File: rtl/wbf_sram.sv
// Behavioural single-port RAM, 1-cycle registered read; stands in for the foundry macro.
module wbf_sram
   import wbf_pkg::*;
#(
   parameter int DW = WBF_DATA_WIDTH,
   parameter int AW = WBF_ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wbf_weight_buffer.sv
// Weight buffer: filled once per layer, then serves in-order reads; data visible 1 cycle after address.
// At most 2 reads outstanding (in flight + skid); AdrRdy drops when the skid cannot absorb another beat.
module wbf_weight_buffer
   import wbf_pkg::*;
#(
   parameter int DATA_WIDTH     = WBF_DATA_WIDTH,
   parameter int WEI_ADDR_WIDTH = WBF_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      TOPWBF_CfgVld,
   input  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum,
   output logic                      WBFTOP_CfgRdy,
   input  logic                      TOPWBF_DatVld,
   input  logic [DATA_WIDTH-1:0]     TOPWBF_Dat,
   output logic                      WBFTOP_DatRdy,
   input  logic                      WCAWBF_AdrVld,
   input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
   output logic                      WBFWCA_AdrRdy,
   output logic                      WBFWCA_DatVld,
   output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
   input  logic                      WCAWBF_DatRdy,
   output logic                      WBFTOP_Err
);

   localparam int NW = WEI_ADDR_WIDTH + 1;

   wbf_state_e                state_q, state_d;
   logic [NW-1:0]             num_q, num_d;
   logic [WEI_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic                      inflight_q, oor_q, err_q, err_d;
   logic [DATA_WIDTH-1:0]     skid_q [SKID_DEPTH];
   logic [SKID_PTR_WIDTH-1:0] skid_wp_q, skid_rp_q;
   logic [SKID_CNT_WIDTH-1:0] skid_cnt_q, skid_cnt_d;

   logic                      fill_hs, adr_hs, oor_now, last_fill;
   logic                      skid_empty, skid_push, skid_pop;
   logic [SKID_CNT_WIDTH:0]   occupancy;
   logic [DATA_WIDTH-1:0]     sram_rdata, rd_beat;
   logic [WEI_ADDR_WIDTH-1:0] sram_addr;

   assign fill_hs   = TOPWBF_DatVld & WBFTOP_DatRdy;
   assign adr_hs    = WCAWBF_AdrVld & WBFWCA_AdrRdy;
   assign oor_now   = {1'b0, WCAWBF_Adr} >= num_q;
   assign last_fill = {1'b0, wr_ptr_q} == (num_q - NW'(1));

   // Out-of-range reads still occupy a slot so ordering is preserved; their beat is forced to zero.
   assign rd_beat    = oor_q ? '0 : sram_rdata;
   assign skid_empty = (skid_cnt_q == '0);
   assign skid_pop   = !skid_empty & WCAWBF_DatRdy;
   assign skid_push  = inflight_q & !(skid_empty & WCAWBF_DatRdy);
   assign occupancy  = {1'b0, skid_cnt_q} + {{SKID_CNT_WIDTH{1'b0}}, inflight_q};

   assign WBFTOP_CfgRdy = (state_q == ST_IDLE) & ~rst_n;
   assign WBFTOP_DatRdy = (state_q == ST_FILL);
   assign WBFWCA_AdrRdy = (state_q == ST_SERVE) &
                          (occupancy < (SKID_CNT_WIDTH + 1)'(SKID_DEPTH));
   assign WBFWCA_DatVld = !skid_empty | inflight_q;
   assign WBFWCA_Dat    = !skid_empty ? skid_q[skid_rp_q] : (inflight_q ? rd_beat : '0);
   assign WBFTOP_Err    = err_q;

   assign sram_addr = (state_q == ST_FILL) ? wr_ptr_q : WCAWBF_Adr;

   wbf_sram #(
      .DW (DATA_WIDTH),
      .AW (WEI_ADDR_WIDTH)
   ) u_sram (
      .clk     (clk),
      .we_i    (fill_hs),
      .re_i    (adr_hs),
      .addr_i  (sram_addr),
      .wdata_i (TOPWBF_Dat),
      .rdata_o (sram_rdata)
   );

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      wr_ptr_d = wr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (TOPWBF_CfgVld) begin
               state_d  = ST_FILL;
               num_d    = (TOPWBF_CfgNum == '0) ? {1'b1, {WEI_ADDR_WIDTH{1'b0}}} : TOPWBF_CfgNum;
               wr_ptr_d = '0;
            end
         end
         ST_FILL: begin
            if (fill_hs) begin
               if (last_fill) begin
                  state_d = ST_SERVE;
               end else begin
                  wr_ptr_d = wr_ptr_q + WEI_ADDR_WIDTH'(1);
               end
            end
         end
         ST_SERVE: begin
            if (TOPWBF_CfgVld) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!inflight_q && skid_empty) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      err_d = err_q | (adr_hs & oor_now);
      if (state_q == ST_IDLE) begin
         err_d = 1'b0;
      end
   end

   always_comb begin
      skid_cnt_d = skid_cnt_q;
      if (skid_push && !skid_pop) begin
         skid_cnt_d = skid_cnt_q + SKID_CNT_WIDTH'(1);
      end else if (!skid_push && skid_pop) begin
         skid_cnt_d = skid_cnt_q - SKID_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= ST_IDLE;
         num_q      <= '0;
         wr_ptr_q   <= '0;
         inflight_q <= 1'b0;
         oor_q      <= 1'b0;
         err_q      <= 1'b0;
         skid_cnt_q <= '0;
         skid_wp_q  <= '0;
         skid_rp_q  <= '0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         wr_ptr_q   <= wr_ptr_d;
         inflight_q <= adr_hs;
         oor_q      <= adr_hs & oor_now;
         err_q      <= err_d;
         skid_cnt_q <= skid_cnt_d;
         if (skid_push) begin
            skid_wp_q <= skid_wp_q + SKID_PTR_WIDTH'(1);
         end
         if (skid_pop) begin
            skid_rp_q <= skid_rp_q + SKID_PTR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (skid_push) begin
         skid_q[skid_wp_q] <= rd_beat;
      end
   end

endmodule

// File: tb/tb_wbf_weight_buffer.sv
// Directed bench for wbf_weight_buffer: per-cycle vector tables plus hand sequences for fill and reset.
module tb_wbf_weight_buffer;

   localparam int DW = 8;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_vld;
   logic [AW:0]   cfg_num;
   logic          cfg_rdy;
   logic          fill_vld;
   logic [DW-1:0] fill_dat;
   logic          fill_rdy;
   logic          adr_vld;
   logic [AW-1:0] adr;
   logic          adr_rdy;
   logic          dat_vld;
   logic [DW-1:0] dat;
   logic          dat_rdy;
   logic          err;

   always #5 clk = ~clk;

   wbf_weight_buffer #(
      .DATA_WIDTH     (DW),
      .WEI_ADDR_WIDTH (AW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .TOPWBF_CfgVld (cfg_vld),
      .TOPWBF_CfgNum (cfg_num),
      .WBFTOP_CfgRdy (cfg_rdy),
      .TOPWBF_DatVld (fill_vld),
      .TOPWBF_Dat    (fill_dat),
      .WBFTOP_DatRdy (fill_rdy),
      .WCAWBF_AdrVld (adr_vld),
      .WCAWBF_Adr    (adr),
      .WBFWCA_AdrRdy (adr_rdy),
      .WBFWCA_DatVld (dat_vld),
      .WBFWCA_Dat    (dat),
      .WCAWBF_DatRdy (dat_rdy),
      .WBFTOP_Err    (err)
   );

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic          cfg_vld;
      logic          adr_vld;
      logic [AW-1:0] adr;
      logic          dat_rdy;
      logic          e_cfg_rdy;
      logic          e_adr_rdy;
      logic          e_dat_vld;
      logic [DW-1:0] e_dat;
      logic          e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input int cv, input int av, input int a, input int dr,
                      input int ecr, input int ear, input int edv, input int ed, input int ee);
      vec_t v;
      v.cfg_vld   = cv[0];
      v.adr_vld   = av[0];
      v.adr       = AW'(a);
      v.dat_rdy   = dr[0];
      v.e_cfg_rdy = ecr[0];
      v.e_adr_rdy = ear[0];
      v.e_dat_vld = edv[0];
      v.e_dat     = DW'(ed);
      v.e_err     = ee[0];
      tbl.push_back(v);
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(negedge clk);
         cfg_vld = tbl[i].cfg_vld;
         adr_vld = tbl[i].adr_vld;
         adr     = tbl[i].adr;
         dat_rdy = tbl[i].dat_rdy;
         #1;
         chk("cfg_rdy", i, 32'(cfg_rdy), 32'(tbl[i].e_cfg_rdy));
         chk("adr_rdy", i, 32'(adr_rdy), 32'(tbl[i].e_adr_rdy));
         chk("dat_vld", i, 32'(dat_vld), 32'(tbl[i].e_dat_vld));
         chk("dat",     i, 32'(dat),     32'(tbl[i].e_dat));
         chk("err",     i, 32'(err),     32'(tbl[i].e_err));
      end
      @(negedge clk);
      cfg_vld = 1'b0;
      adr_vld = 1'b0;
   endtask

   task automatic do_cfg(input int n);
      @(negedge clk);
      cfg_vld = 1'b1;
      cfg_num = (AW + 1)'(n);
      @(negedge clk);
      cfg_vld = 1'b0;
   endtask

   task automatic do_fill(input int n, input int start, input int step);
      for (int i = 0; i < n; i++) begin
         if (i != 0) @(negedge clk);
         fill_vld = 1'b1;
         fill_dat = DW'(start + i * step);
         if (i == n - 1) begin
            #1;
            chk("fill_rdy_last", n, 32'(fill_rdy), 32'd1);
         end
      end
      @(negedge clk);
      fill_vld = 1'b0;
      #1;
      chk("fill_rdy_serve", n, 32'(fill_rdy), 32'd0);
      chk("adr_rdy_serve",  n, 32'(adr_rdy),  32'd1);
   endtask

   int p0, p1, p2, p3;

   initial begin
      rst_n    = 1'b1;
      cfg_vld  = 1'b0;
      cfg_num  = '0;
      fill_vld = 1'b0;
      fill_dat = '0;
      adr_vld  = 1'b0;
      adr      = '0;
      dat_rdy  = 1'b1;

      // Fill-and-read, backpressure, out-of-range, then SERVE->DRAIN->IDLE clearing Err.
      p0 = tbl.size();
      add(0,1,3,1, 0,1,0,8'h00,0);
      add(0,1,0,1, 0,1,1,8'h44,0);
      add(0,1,2,1, 0,1,1,8'h11,0);
      add(0,0,0,1, 0,1,1,8'h33,0);
      add(0,0,0,1, 0,1,0,8'h00,0);
      add(0,1,0,0, 0,1,0,8'h00,0);
      add(0,1,1,0, 0,1,1,8'h11,0);
      add(0,1,2,0, 0,0,1,8'h11,0);
      add(0,1,2,0, 0,0,1,8'h11,0);
      add(0,1,2,1, 0,0,1,8'h11,0);
      add(0,1,2,1, 0,1,1,8'h22,0);
      add(0,0,0,1, 0,1,1,8'h33,0);
      add(0,0,0,1, 0,1,0,8'h00,0);
      add(0,1,9,1, 0,1,0,8'h00,0);
      add(0,1,1,1, 0,1,1,8'h00,1);
      add(0,0,0,1, 0,1,1,8'h22,1);
      add(0,0,0,1, 0,1,0,8'h00,1);
      add(1,0,0,1, 0,1,0,8'h00,1);
      add(0,0,0,1, 0,0,0,8'h00,1);
      add(0,0,0,1, 1,0,0,8'h00,1);
      add(0,0,0,1, 1,0,0,8'h00,0);
      // Drain with two reads pending under backpressure.
      p1 = tbl.size();
      add(0,1,0,0, 0,1,0,8'h00,0);
      add(0,1,1,0, 0,1,1,8'hA0,0);
      add(1,0,0,0, 0,0,1,8'hA0,0);
      add(0,0,0,0, 0,0,1,8'hA0,0);
      add(0,1,2,0, 0,0,1,8'hA0,0);
      add(0,0,0,1, 0,0,1,8'hA0,0);
      add(0,0,0,1, 0,0,1,8'hA1,0);
      add(0,0,0,1, 0,0,0,8'h00,0);
      add(0,0,0,1, 1,0,0,8'h00,0);
      // Full-depth reads: top and bottom addresses are in range.
      p2 = tbl.size();
      add(0,1,255,1, 0,1,0,8'h00,0);
      add(0,1,0,1,   0,1,1,8'hFF,0);
      add(0,0,0,1,   0,1,1,8'h00,0);
      add(0,0,0,1,   0,1,0,8'h00,0);
      p3 = tbl.size();

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_cfg_rdy",  0, 32'(cfg_rdy),  32'd0);
      chk("rst_fill_rdy", 0, 32'(fill_rdy), 32'd0);
      chk("rst_adr_rdy",  0, 32'(adr_rdy),  32'd0);
      chk("rst_dat_vld",  0, 32'(dat_vld),  32'd0);
      chk("rst_dat",      0, 32'(dat),      32'd0);
      chk("rst_err",      0, 32'(err),      32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("idle_cfg_rdy", 0, 32'(cfg_rdy), 32'd1);

      do_cfg(4);
      do_fill(4, 8'h11, 8'h11);
      apply(p0, p1);

      do_cfg(4);
      do_fill(4, 8'hA0, 1);
      apply(p1, p2);

      do_cfg(0);
      do_fill(256, 0, 1);
      apply(p2, p3);

      // Reset lands while a read is in flight; the beat must never surface.
      @(negedge clk);
      adr_vld = 1'b1;
      adr     = 8'd5;
      dat_rdy = 1'b0;
      #1;
      chk("mid_adr_rdy", 0, 32'(adr_rdy), 32'd1);
      @(negedge clk);
      adr_vld = 1'b0;
      #1;
      chk("mid_dat_vld", 0, 32'(dat_vld), 32'd1);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_dat_vld", 0, 32'(dat_vld), 32'd0);
      chk("mid_rst_adr_rdy", 0, 32'(adr_rdy), 32'd0);
      chk("mid_rst_cfg_rdy", 0, 32'(cfg_rdy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b0;
      dat_rdy = 1'b1;
      #1;
      chk("post_rst_cfg_rdy", 0, 32'(cfg_rdy), 32'd1);
      chk("post_rst_adr_rdy", 0, 32'(adr_rdy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("post_rst_dat_vld", i, 32'(dat_vld), 32'd0);
         chk("post_rst_dat",     i, 32'(dat),     32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
